// File: rtl/camera_downsampler_if.sv
// Camera pixel bus plus frame-buffer write port.
// The sensor side drives timing/data, the capture block drives the RAM write.
interface camera_downsampler_if #(
   parameter int ADDR_W = 15
);
   logic              PCLK;
   logic              HREF;
   logic              VSYNC;
   logic [7:0]        CAM_DATA;
   logic              W_EN;
   logic [ADDR_W-1:0] W_ADDR;
   logic [7:0]        W_DATA;

   modport master (
      output PCLK, HREF, VSYNC, CAM_DATA,
      input  W_EN, W_ADDR, W_DATA
   );

   modport slave (
      input  PCLK, HREF, VSYNC, CAM_DATA,
      output W_EN, W_ADDR, W_DATA
   );
endinterface

// File: rtl/camera_downsampler.sv
// OV7670 capture front end: oversampled camera bus to RGB332 frame-buffer
// writes with decimation, frame-aligned start/stop and sticky error flags.
module camera_downsampler #(
   parameter int WIDTH     = 176,
   parameter int HEIGHT    = 144,
   parameter int ADDR_W    = 15,
   parameter int DECIM     = 1,
   parameter int BYTE_SWAP = 0
) (
   input  logic                 i_clk,
   input  logic                 i_reset,
   input  logic                 i_enable,
   input  logic [1:0]           i_mode,
   camera_downsampler_if.slave  cam,
   output logic                 o_frame_done,
   output logic                 o_busy,
   output logic [7:0]           o_line_count,
   output logic                 o_line_err,
   output logic                 o_clip_err
);
   localparam int XW = $clog2(WIDTH + 1);
   localparam int YW = $clog2(HEIGHT + 1);
   localparam int DW = (DECIM > 1) ? $clog2(DECIM) : 1;
   localparam logic [XW-1:0]     XMAX = XW'(WIDTH);
   localparam logic [YW-1:0]     YMAX = YW'(HEIGHT);
   localparam logic [DW-1:0]     DLAST = DW'(DECIM - 1);
   localparam logic [ADDR_W-1:0] LSTEP = ADDR_W'(WIDTH);

   typedef enum logic [1:0] {S_IDLE, S_ARMED, S_CAPTURE} state_t;

   state_t r_state, w_next;

   logic [1:0]        r_pclk_s, r_href_s, r_vsync_s;
   logic              r_pclk_d, r_href_d, r_vsync_d;
   logic [7:0]        r_data_s1, r_data_s2;
   logic [1:0]        r_mode;
   logic              r_phase;
   logic [7:0]        r_b0;
   logic [DW-1:0]     r_xph, r_yph;
   logic [XW-1:0]     r_xo;
   logic [YW-1:0]     r_yo;
   logic [ADDR_W-1:0] r_base;
   logic              r_line_wr;
   logic [7:0]        r_lcnt;
   logic              r_wen;
   logic [ADDR_W-1:0] r_waddr;
   logic [7:0]        r_wdata;
   logic              r_fdone;
   logic [7:0]        r_lcount;
   logic              r_line_err, r_clip_err;

   logic       w_pclk_rise, w_href_fall, w_vsync_rise, w_byte;
   logic       w_start, w_frame_end, w_keep, w_in;
   logic [7:0] w_hi, w_lo, w_pix;

   assign w_pclk_rise  = r_pclk_s[1] & ~r_pclk_d;
   assign w_href_fall  = ~r_href_s[1] & r_href_d;
   assign w_vsync_rise = r_vsync_s[1] & ~r_vsync_d;
   assign w_byte       = w_pclk_rise & r_href_s[1];
   assign w_start      = (r_state == S_ARMED) && w_vsync_rise;
   assign w_frame_end  = (r_state == S_CAPTURE) && w_vsync_rise;
   assign w_keep       = (r_xph == '0) && (r_yph == '0);
   assign w_in         = (r_xo < XMAX) && (r_yo < YMAX);

   // Two-flop synchronisers plus one delay stage for edge detection
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_pclk_s  <= '0;
         r_href_s  <= '0;
         r_vsync_s <= '0;
         r_pclk_d  <= 1'b0;
         r_href_d  <= 1'b0;
         r_vsync_d <= 1'b0;
         r_data_s1 <= '0;
         r_data_s2 <= '0;
      end else begin
         r_pclk_s  <= {r_pclk_s[0], cam.PCLK};
         r_href_s  <= {r_href_s[0], cam.HREF};
         r_vsync_s <= {r_vsync_s[0], cam.VSYNC};
         r_pclk_d  <= r_pclk_s[1];
         r_href_d  <= r_href_s[1];
         r_vsync_d <= r_vsync_s[1];
         r_data_s1 <= cam.CAM_DATA;
         r_data_s2 <= r_data_s1;
      end
   end

   // Capture state register
   always_ff @(posedge i_clk) begin
      if (i_reset) r_state <= S_IDLE;
      else         r_state <= w_next;
   end

   // Next state: start and stop only on the VSYNC rise
   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE:    if (i_enable) w_next = S_ARMED;
         S_ARMED:   if (w_vsync_rise) w_next = S_CAPTURE;
         S_CAPTURE: if (w_vsync_rise && !i_enable) w_next = S_IDLE;
         default:   w_next = S_IDLE;
      endcase
   end

   // Byte ordering and RGB332 conversion of the pixel being completed
   always_comb begin
      w_hi = r_b0;
      w_lo = r_data_s2;
      if (BYTE_SWAP != 0) begin
         w_hi = r_data_s2;
         w_lo = r_b0;
      end
      unique case (r_mode)
         2'd0:    w_pix = {w_hi[7:5], w_hi[2:0], w_lo[4:3]};
         2'd1:    w_pix = {w_hi[6:4], w_hi[1:0], w_lo[7], w_lo[4:3]};
         2'd2:    w_pix = {w_hi[3:1], w_lo[7:5], w_lo[3:2]};
         default: w_pix = {w_hi[7:5], w_hi[7:5], w_hi[7:6]};
      endcase
   end

   // Pixel/line counters, write port, frame bookkeeping and error flags
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_mode     <= '0;
         r_phase    <= 1'b0;
         r_b0       <= '0;
         r_xph      <= '0;
         r_yph      <= '0;
         r_xo       <= '0;
         r_yo       <= '0;
         r_base     <= '0;
         r_line_wr  <= 1'b0;
         r_lcnt     <= '0;
         r_wen      <= 1'b0;
         r_waddr    <= '0;
         r_wdata    <= '0;
         r_fdone    <= 1'b0;
         r_lcount   <= '0;
         r_line_err <= 1'b0;
         r_clip_err <= 1'b0;
      end else begin
         r_wen   <= 1'b0;
         r_fdone <= 1'b0;
         if (w_start || w_frame_end) begin
            r_mode    <= i_mode;
            r_phase   <= 1'b0;
            r_xph     <= '0;
            r_yph     <= '0;
            r_xo      <= '0;
            r_yo      <= '0;
            r_base    <= '0;
            r_line_wr <= 1'b0;
            r_lcnt    <= '0;
            if (w_start) begin
               r_line_err <= 1'b0;
               r_clip_err <= 1'b0;
            end
            if (w_frame_end) begin
               r_fdone  <= 1'b1;
               r_lcount <= r_lcnt;
            end
         end else if (r_state == S_CAPTURE) begin
            if (w_byte) begin
               r_phase <= ~r_phase;
               if (!r_phase) begin
                  r_b0 <= r_data_s2;
               end else begin
                  r_xph <= (r_xph == DLAST) ? '0 : r_xph + DW'(1);
                  if (w_keep) begin
                     if (w_in) begin
                        r_wen     <= 1'b1;
                        r_waddr   <= r_base + ADDR_W'(r_xo);
                        r_wdata   <= w_pix;
                        r_line_wr <= 1'b1;
                     end else begin
                        r_clip_err <= 1'b1;
                     end
                     if (r_xo != XMAX) r_xo <= r_xo + XW'(1);
                  end
               end
            end
            if (w_href_fall) begin
               if (r_phase) r_line_err <= 1'b1;
               r_phase   <= 1'b0;
               r_xph     <= '0;
               r_xo      <= '0;
               r_line_wr <= 1'b0;
               r_yph     <= (r_yph == DLAST) ? '0 : r_yph + DW'(1);
               if (r_yph == '0) begin
                  if (r_yo != YMAX) begin
                     r_yo   <= r_yo + YW'(1);
                     r_base <= r_base + LSTEP;
                  end
                  if (r_line_wr && r_lcnt != 8'hFF) r_lcnt <= r_lcnt + 8'd1;
               end
            end
         end
      end
   end

   assign cam.W_EN     = r_wen;
   assign cam.W_ADDR   = r_waddr;
   assign cam.W_DATA   = r_wdata;
   assign o_frame_done = r_fdone;
   assign o_busy       = (r_state == S_CAPTURE);
   assign o_line_count = r_lcount;
   assign o_line_err   = r_line_err;
   assign o_clip_err   = r_clip_err;
endmodule

// File: tb/tb_camera_downsampler.sv
// Directed bench for camera_downsampler: two instances share one camera bus,
// expected writes are queued per instance and checked as they appear.
module tb_camera_downsampler;
   localparam int AW = 15;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, en_a, en_b;
   logic [1:0] mode;
   logic       pclk, href, vsync;
   logic [7:0] cdata;

   camera_downsampler_if #(.ADDR_W(AW)) ifa ();
   camera_downsampler_if #(.ADDR_W(AW)) ifb ();

   assign ifa.PCLK = pclk;
   assign ifa.HREF = href;
   assign ifa.VSYNC = vsync;
   assign ifa.CAM_DATA = cdata;
   assign ifb.PCLK = pclk;
   assign ifb.HREF = href;
   assign ifb.VSYNC = vsync;
   assign ifb.CAM_DATA = cdata;

   logic       fd_a, busy_a, le_a, ce_a;
   logic [7:0] lc_a;
   logic       fd_b, busy_b, le_b, ce_b;
   logic [7:0] lc_b;

   camera_downsampler #(
      .WIDTH(4), .HEIGHT(2), .ADDR_W(AW), .DECIM(1), .BYTE_SWAP(0)
   ) u_a (
      .i_clk(clk), .i_reset(rst), .i_enable(en_a), .i_mode(mode),
      .cam(ifa), .o_frame_done(fd_a), .o_busy(busy_a),
      .o_line_count(lc_a), .o_line_err(le_a), .o_clip_err(ce_a)
   );

   camera_downsampler #(
      .WIDTH(4), .HEIGHT(2), .ADDR_W(AW), .DECIM(2), .BYTE_SWAP(1)
   ) u_b (
      .i_clk(clk), .i_reset(rst), .i_enable(en_b), .i_mode(mode),
      .cam(ifb), .o_frame_done(fd_b), .o_busy(busy_b),
      .o_line_count(lc_b), .o_line_err(le_b), .o_clip_err(ce_b)
   );

   int tests = 0;
   int fails = 0;
   int fd_a_n = 0;
   int fd_b_n = 0;
   logic [AW+7:0] qa[$];
   logic [AW+7:0] qb[$];

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      logic [AW+7:0] e;
      @(posedge clk);
      #1;
      if (ifa.W_EN !== 1'b0) begin
         e = (qa.size() > 0) ? qa.pop_front() : '1;
         check("wr_a", 32'({ifa.W_ADDR, ifa.W_DATA}), 32'(e));
      end
      if (ifb.W_EN !== 1'b0) begin
         e = (qb.size() > 0) ? qb.pop_front() : '1;
         check("wr_b", 32'({ifb.W_ADDR, ifb.W_DATA}), 32'(e));
      end
      if (fd_a === 1'b1) fd_a_n++;
      if (fd_b === 1'b1) fd_b_n++;
   endtask

   task automatic ticks(input int n);
      repeat (n) tick();
   endtask

   task automatic send_byte(input logic [7:0] d);
      pclk = 1'b0;
      cdata = d;
      ticks(4);
      pclk = 1'b1;
      ticks(4);
   endtask

   task automatic send_px(input logic [7:0] b0, input logic [7:0] b1);
      send_byte(b0);
      send_byte(b1);
   endtask

   task automatic href_up();
      pclk = 1'b0;
      href = 1'b1;
      ticks(4);
   endtask

   task automatic href_dn();
      pclk = 1'b0;
      ticks(4);
      href = 1'b0;
      ticks(8);
   endtask

   task automatic send_line(input int npx, input logic [7:0] b0,
                            input logic [7:0] b1, input bit extra);
      href_up();
      repeat (npx) send_px(b0, b1);
      if (extra) send_byte(b0);
      href_dn();
   endtask

   task automatic vs_pulse();
      vsync = 1'b1;
      ticks(6);
      vsync = 1'b0;
      ticks(6);
   endtask

   task automatic push_a(input int addr, input logic [7:0] d);
      qa.push_back({AW'(addr), d});
   endtask

   task automatic push_b(input int addr, input logic [7:0] d);
      qb.push_back({AW'(addr), d});
   endtask

   initial begin
      rst = 1'b1;
      en_a = 1'b0;
      en_b = 1'b0;
      mode = 2'd0;
      pclk = 1'b0;
      href = 1'b0;
      vsync = 1'b0;
      cdata = 8'h00;
      ticks(3);
      check("rst_busy", 32'(busy_a), 32'd0);
      check("rst_wen", 32'(ifa.W_EN), 32'd0);
      check("rst_waddr", 32'(ifa.W_ADDR), 32'd0);
      check("rst_wdata", 32'(ifa.W_DATA), 32'd0);
      check("rst_lc", 32'(lc_a), 32'd0);
      check("rst_errs", 32'({le_a, ce_a, fd_a}), 32'd0);
      rst = 1'b0;
      ticks(2);

      // B: decimate by 2, swapped bytes, 8 px x 4 lines
      en_b = 1'b1;
      ticks(2);
      vs_pulse();
      check("b_busy", 32'(busy_b), 32'd1);
      for (int i = 0; i < 8; i++) push_b(i, 8'hE3);
      repeat (4) send_line(8, 8'h1F, 8'hF8, 1'b0);
      en_b = 1'b0;
      en_a = 1'b1;
      ticks(2);
      fd_b_n = 0;
      vs_pulse();
      check("b_fd", 32'(fd_b_n), 32'd1);
      check("b_lc", 32'(lc_b), 32'd2);
      check("b_idle", 32'(busy_b), 32'd0);
      check("b_q", 32'(qb.size()), 32'd0);
      check("a_busy", 32'(busy_a), 32'd1);

      // A frame 1: RGB565, 2 lines x 4 px
      for (int i = 0; i < 8; i++) push_a(i, 8'hE3);
      repeat (2) send_line(4, 8'hF8, 8'h1F, 1'b0);
      mode = 2'd2;
      fd_a_n = 0;
      vs_pulse();
      check("f1_fd", 32'(fd_a_n), 32'd1);
      check("f1_lc", 32'(lc_a), 32'd2);
      check("f1_q", 32'(qa.size()), 32'd0);
      check("f1_errs", 32'({le_a, ce_a}), 32'd0);
      check("f1_busy", 32'(busy_a), 32'd1);

      // A frame 2: RGB444
      push_a(0, 8'hFC);
      send_line(1, 8'h0F, 8'hF0, 1'b0);
      mode = 2'd3;
      vs_pulse();
      check("f2_lc", 32'(lc_a), 32'd1);
      check("f2_q", 32'(qa.size()), 32'd0);

      // A frame 3: gray
      push_a(0, 8'h92);
      send_line(1, 8'h80, 8'h80, 1'b0);
      mode = 2'd0;
      vs_pulse();
      check("f3_q", 32'(qa.size()), 32'd0);

      // A frame 4: clipped line then odd-byte line
      for (int i = 0; i < 4; i++) push_a(i, 8'hE3);
      send_line(5, 8'hF8, 8'h1F, 1'b0);
      check("clip", 32'({le_a, ce_a}), 32'b01);
      for (int i = 4; i < 7; i++) push_a(i, 8'hE3);
      send_line(3, 8'hF8, 8'h1F, 1'b1);
      check("lerr", 32'({le_a, ce_a}), 32'b11);
      vs_pulse();
      check("f4_lc", 32'(lc_a), 32'd2);
      check("f4_q", 32'(qa.size()), 32'd0);
      check("f4_sticky", 32'({le_a, ce_a}), 32'b11);

      // A frame 5: ENABLE dropped mid-line, frame still completes
      for (int i = 0; i < 4; i++) push_a(i, 8'hE3);
      href_up();
      repeat (2) send_px(8'hF8, 8'h1F);
      en_a = 1'b0;
      repeat (2) send_px(8'hF8, 8'h1F);
      href_dn();
      check("f5_busy_mid", 32'(busy_a), 32'd1);
      fd_a_n = 0;
      vs_pulse();
      check("f5_fd", 32'(fd_a_n), 32'd1);
      check("f5_idle", 32'(busy_a), 32'd0);
      check("f5_lc", 32'(lc_a), 32'd1);
      check("f5_q", 32'(qa.size()), 32'd0);

      // ENABLE raised mid-frame: nothing written until next VSYNC
      href_up();
      send_px(8'hF8, 8'h1F);
      en_a = 1'b1;
      repeat (3) send_px(8'hF8, 8'h1F);
      href_dn();
      check("arm_busy", 32'(busy_a), 32'd0);
      vs_pulse();
      check("arm_cap", 32'(busy_a), 32'd1);
      check("arm_clr", 32'({le_a, ce_a}), 32'd0);

      // RESET during a line
      push_a(0, 8'hE3);
      push_a(1, 8'hE3);
      href_up();
      repeat (2) send_px(8'hF8, 8'h1F);
      send_byte(8'hF8);
      rst = 1'b1;
      tick();
      check("r_busy", 32'(busy_a), 32'd0);
      check("r_flags", 32'({le_a, ce_a, fd_a, ifa.W_EN}), 32'd0);
      check("r_addr", 32'(ifa.W_ADDR), 32'd0);
      check("r_lc", 32'(lc_a), 32'd0);
      rst = 1'b0;
      send_byte(8'h1F);
      send_px(8'hF8, 8'h1F);
      href_dn();
      ticks(10);
      check("r_q", 32'(qa.size()), 32'd0);
      check("r_busy2", 32'(busy_a), 32'd0);
      en_a = 1'b0;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/camera_downsampler.md
# camera_downsampler

Parametrised OV7670 capture front end: oversamples the camera's PCLK/HREF/VSYNC/D[7:0] bus on the system clock and converts each two-byte pixel to RGB332. It decimates by a programmable factor and writes the result into the frame-buffer M9K (write port) as a linear address `x + y*WIDTH`. It sits between the GPIO_1 camera pins and `Dual_Port_RAM_M9K`, replacing the ad-hoc PCLK-clocked downsampler logic with frame-aligned start/stop, selectable pixel formats and error reporting.

## Interface
Single clock domain: one clock; reset is synchronous and active-high. Camera inputs are asynchronous and synchronised internally.

Parameters:
- `WIDTH`, 176: stored frame width in output pixels.
- `HEIGHT`, 144: stored frame height in output lines.
- `ADDR_W`, 15: write-address width; must satisfy 2^ADDR_W ≥ WIDTH*HEIGHT.
- `DECIM`, 1: decimation factor (1, 2 or 4); keeps every DECIM-th pixel and every DECIM-th line, starting at index 0.
- `BYTE_SWAP`, 0: 1 means the camera sends the low pixel byte first.

Ports:
- `CLK`, in, 1: system clock; must be ≥ 4× PCLK frequency.
- `RESET`, in, 1: synchronous active-high reset.
- `ENABLE`, in, 1: capture request; acted on only at frame boundaries.
- `MODE`, in, 2: pixel format. 0 = RGB565, 1 = RGB555, 2 = RGB444 (xR GB), 3 = YUV422 gray.
- `PCLK`, `HREF`, `VSYNC`, in, 1 each: camera timing, asynchronous.
- `CAM_DATA`, in, 8: camera data {D7..D0}, asynchronous.
- `W_EN`, out, 1: one-cycle write strobe to the M9K.
- `W_ADDR`, out, ADDR_W: write address.
- `W_DATA`, out, 8: RGB332 pixel.
- `FRAME_DONE`, out, 1: one-cycle pulse at the end of each captured frame.
- `BUSY`, out, 1: high in CAPTURE.
- `LINE_COUNT`, out, 8: lines written in the last completed frame.
- `LINE_ERR`, out, 1: sticky flag, line ended on an odd byte.
- `CLIP_ERR`, out, 1: sticky flag, pixel fell outside WIDTH×HEIGHT.

## Operation
- Input path:
  - PCLK, HREF, VSYNC and CAM_DATA pass through 2-flop synchronisers.
  - `pclk_rise` = sync PCLK high and previous sync PCLK low. Byte sampling happens only on `pclk_rise` with sync HREF = 1.
  - HREF and VSYNC edges are detected on the synchronised signals.
- State machine:
  - IDLE: ENABLE=1 → ARMED.
  - ARMED: VSYNC rise → CAPTURE. On entry to CAPTURE: latch MODE, clear counters, clear LINE_ERR/CLIP_ERR.
  - CAPTURE, on VSYNC rise: pulse FRAME_DONE, load LINE_COUNT, reset counters. Then relatch MODE and stay in CAPTURE if ENABLE=1, else go to IDLE.
  - ENABLE falling mid-frame does not stop capture before the VSYNC rise.
- Byte phase toggles on each sampled byte. Phase 0 latches `b0`; phase 1 forms the pixel, with b0/b1 swapped when BYTE_SWAP=1.
- Conversions:
  - RGB565: {b0[7:5], b0[2:0], b1[4:3]}.
  - RGB555: {b0[6:4], b0[1:0], b1[7], b1[4:3]}.
  - RGB444: {b0[3:1], b1[7:5], b1[3:2]}.
  - Gray (Y=b0): {Y[7:5], Y[7:5], Y[7:6]}.
- Counters:
  - Raw x (pixels) and raw y (lines), each with a decimation phase.
  - Output x/y advance only on kept pixels and lines.
  - W_ADDR is built incrementally: a line base += WIDTH per kept line, plus output x. No multiplier.
- HREF fall in CAPTURE:
  - If phase = 1, set LINE_ERR and discard the byte.
  - Reset raw x and phase.
  - Advance raw y; advance output y if the line was kept.
- Clipping: a kept pixel with output x ≥ WIDTH or output y ≥ HEIGHT is not written and sets CLIP_ERR. Counters saturate; they do not wrap.
- LINE_COUNT counts kept lines with ≥1 write, saturating at 255.

## Timing
- Reset values:
  - State = IDLE.
  - W_EN, FRAME_DONE, BUSY, LINE_ERR, CLIP_ERR = 0.
  - W_ADDR, W_DATA, LINE_COUNT = 0.
  - All counters, phase and synchronisers = 0.
- `pclk_rise` is high on the 3rd CLK edge after PCLK is first sampled high.
- W_EN/W_ADDR/W_DATA are registered and appear 1 cycle after the phase-1 `pclk_rise`. W_ADDR/W_DATA hold until the next write.
- FRAME_DONE and BUSY deassertion occur 1 cycle after the synchronised VSYNC rise.
- Simultaneous HREF fall and `pclk_rise`: the byte is sampled first, then the line-end handling is applied.
- RESET mid-frame: returns to IDLE the next cycle. No W_EN is issued after reset.

## Test plan
- WIDTH=4, HEIGHT=2, DECIM=1, RGB565, ENABLE=1; two lines of 4 pixels, each pixel bytes 0xF8,0x1F → 8 writes, addresses 0..7, data 0xE3, FRAME_DONE on the next VSYNC, LINE_COUNT=2.
- MODE=2, bytes 0x0F,0xF0 → W_DATA=0xFC; MODE=3, Y=0x80 → 0x92; BYTE_SWAP=1 with RGB565 bytes 0x1F,0xF8 → 0xE3.
- DECIM=2, 8 pixels × 4 lines → writes only at addresses 0..3 (line 0) and 4..7 (line 2); LINE_COUNT=2.
- Line of 5 pixels with WIDTH=4 → 4 writes, CLIP_ERR=1. Line with 7 bytes → LINE_ERR=1, 3 writes.
- ENABLE raised mid-frame → no writes until the next VSYNC rise. ENABLE dropped mid-frame → the frame completes, FRAME_DONE pulses, then BUSY=0.
- RESET asserted during a line → next cycle BUSY=0, all flags 0, W_EN stays 0 for the rest of the frame.
